// File: rtl/exponential_block.sv
// Softmax exponential stage: converts each (x - max) difference into e^(x - max)
// with 2^y, y = x*log2(e), 2^f ~= 1+f, and sums every frame of N results.
module exponential_block #(
    parameter int DATA_SIZE      = 32,
    parameter int NUMBER_OF_DATA = 10,
    parameter int FRAC_BITS      = 16
) (
    input  logic                                          clock_i,
    input  logic                                          reset_n_i,
    input  logic                                          start_i,
    input  logic                                          sub_result_valid_i,
    input  logic [DATA_SIZE:0]                            sub_result_i,
    output logic                                          exp_valid_o,
    output logic [FRAC_BITS:0]                            exp_o,
    output logic                                          sum_valid_o,
    output logic [FRAC_BITS+$clog2(NUMBER_OF_DATA):0]     sum_o
);

    localparam int IN_W   = DATA_SIZE + 1;
    localparam int LOG_W  = 17;
    localparam int PROD_W = IN_W + LOG_W;
    localparam int EXP_W  = FRAC_BITS + 1;
    localparam int CNT_W  = $clog2(NUMBER_OF_DATA);
    localparam int SUM_W  = EXP_W + CNT_W;
    localparam int SH_W   = $clog2(FRAC_BITS + 1);

    localparam logic [LOG_W-1:0] LOG2E = 17'd47274;   // log2(e) in Q2.15

    // Stage 1 datapath: clamp positives to zero, scale by log2(e)
    logic [IN_W-1:0]          xc;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] y;

    assign xc   = sub_result_i[IN_W-1] ? sub_result_i : '0;
    assign prod = $signed({{LOG_W{xc[IN_W-1]}}, xc}) * $signed({{IN_W{1'b0}}, LOG2E});
    assign y    = prod >>> 15;

    // Stage 2 datapath: split y into integer part n (<= 0) and fraction f
    logic signed [PROD_W-1:0] y_q;
    logic signed [PROD_W-1:0] n;
    logic [PROD_W-1:0]        neg_n;
    logic [EXP_W-1:0]         m;
    logic                     too_small;

    assign n         = y_q >>> FRAC_BITS;
    assign neg_n     = -n;
    assign m         = {1'b1, y_q[FRAC_BITS-1:0]};
    assign too_small = neg_n > PROD_W'(FRAC_BITS);

    logic             v1, v2;
    logic [EXP_W-1:0] m_q;
    logic [SH_W-1:0]  sh_q;
    logic             zero_q;

    // Three-stage exponential pipeline; valid bits travel with the data
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            exp_valid_o <= 1'b0;
            y_q         <= '0;
            m_q         <= '0;
            sh_q        <= '0;
            zero_q      <= 1'b0;
            exp_o       <= '0;
        end else if (!start_i) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            exp_valid_o <= 1'b0;
        end else begin
            v1          <= sub_result_valid_i;
            v2          <= v1;
            exp_valid_o <= v2;
            if (sub_result_valid_i) begin
                y_q <= y;
            end
            if (v1) begin
                m_q    <= m;
                sh_q   <= neg_n[SH_W-1:0];
                zero_q <= too_small;
            end
            if (v2) begin
                exp_o <= zero_q ? '0 : (m_q >> sh_q);
            end
        end
    end

    logic [CNT_W-1:0] count;
    logic [SUM_W-1:0] acc;

    // Frame accumulator: publish the sum on the N-th result and restart at once
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count       <= '0;
            acc         <= '0;
            sum_o       <= '0;
            sum_valid_o <= 1'b0;
        end else begin
            sum_valid_o <= 1'b0;
            if (!start_i) begin
                count <= '0;
                acc   <= '0;
            end else if (exp_valid_o) begin
                if (count == CNT_W'(NUMBER_OF_DATA - 1)) begin
                    sum_o       <= acc + SUM_W'(exp_o);
                    sum_valid_o <= 1'b1;
                    acc         <= '0;
                    count       <= '0;
                end else begin
                    acc   <= acc + SUM_W'(exp_o);
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exponential_block.sv
// Self-checking bench for exponential_block: scoreboard of expected exp values
// and frame sums, filled when stimulus is driven and drained by a monitor.
module tb_exponential_block;

    localparam int N = 10;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic        start_i;
    logic        sub_result_valid_i;
    logic [32:0] sub_result_i;
    logic        exp_valid_o;
    logic [16:0] exp_o;
    logic        sum_valid_o;
    logic [20:0] sum_o;

    exponential_block #(
        .DATA_SIZE(32),
        .NUMBER_OF_DATA(N),
        .FRAC_BITS(16)
    ) dut (
        .clock_i(clock_i),
        .reset_n_i(reset_n_i),
        .start_i(start_i),
        .sub_result_valid_i(sub_result_valid_i),
        .sub_result_i(sub_result_i),
        .exp_valid_o(exp_valid_o),
        .exp_o(exp_o),
        .sum_valid_o(sum_valid_o),
        .sum_o(sum_o)
    );

    always #5 clock_i = ~clock_i;

    int errors = 0;
    int checks = 0;

    longint exp_q[$];
    longint sum_q[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    longint model_last_sum = 0;
    longint last_sum = 0;
    longint prev_sum = 0;
    int     sums_seen = 0;

    task automatic check(input string tag, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference e^x via 2^(x*log2e) with linear fraction approximation
    function automatic longint exp_model(input longint x);
        longint xc, p, y, n, f;
        xc = (x > 0) ? 0 : x;
        p  = xc * 47274;
        y  = p >>> 15;
        n  = y >>> 16;
        f  = y - (n <<< 16);
        if (-n > 16) return 0;
        return (65536 + f) >>> (-n);
    endfunction

    function automatic logic [32:0] rnd33();
        return 33'({$urandom(), $urandom()});
    endfunction

    task automatic flush();
        exp_q.delete();
        sum_q.delete();
        m_acc = 0;
        m_cnt = 0;
    endtask

    task automatic drive(input logic s, input logic v, input logic [32:0] x);
        @(negedge clock_i);
        start_i            = s;
        sub_result_valid_i = v;
        sub_result_i       = x;
    endtask

    task automatic send(input longint x, input longint want);
        drive(1'b1, 1'b1, 33'(x));
        exp_q.push_back(want);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(start_i, 1'b0, rnd33());
    endtask

    task automatic stop_frame();
        drive(1'b0, 1'($urandom_range(0, 1)), rnd33());
        @(posedge clock_i);
        #2;
        flush();
    endtask

    task automatic reset_pulse();
        @(negedge clock_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        flush();
        check("rst_pulse_exp_valid", exp_valid_o, 0);
        check("rst_pulse_sum_o", sum_o, 0);
        repeat (2) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd33());
        @(posedge clock_i);
        #3;
        reset_n_i = 1'b1;
    endtask

    // Monitor: compare each output pulse against the scoreboard
    initial begin
        forever begin
            @(posedge clock_i);
            #1;
            if (exp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("exp_spurious", 1, 0);
                end else begin
                    longint e;
                    e = exp_q.pop_front();
                    check("exp", longint'(exp_o), e);
                    m_acc += e;
                    m_cnt++;
                    if (m_cnt == N) begin
                        sum_q.push_back(m_acc);
                        model_last_sum = m_acc;
                        m_acc = 0;
                        m_cnt = 0;
                    end
                end
            end
            if (sum_valid_o) begin
                if (sum_q.size() == 0) begin
                    check("sum_spurious", 1, 0);
                end else begin
                    check("sum", longint'(sum_o), sum_q.pop_front());
                end
                prev_sum  = last_sum;
                last_sum  = longint'(sum_o);
                sums_seen++;
            end
        end
    end

    initial begin
        int base;
        longint x;

        // Reset with random inputs, then release mid-cycle
        reset_n_i = 1'b0;
        start_i = 1'b0;
        sub_result_valid_i = 1'b0;
        sub_result_i = '0;
        repeat (4) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd33());
        #1;
        check("rst_exp_valid", exp_valid_o, 0);
        check("rst_exp_o", exp_o, 0);
        check("rst_sum_valid", sum_valid_o, 0);
        check("rst_sum_o", sum_o, 0);
        @(posedge clock_i);
        #3;
        reset_n_i = 1'b1;
        drive(1'b0, 1'b0, '0);
        idle(3);

        // Single-sample points and boundaries
        send(0, 65536);
        idle(4);
        send(-65536, 25515);
        send(-2097152, 0);
        send(327680, 65536);
        send(-1048576, 0);
        send(-1, exp_model(-1));
        for (int i = 0; i < 3; i++) begin
            x = -longint'($urandom_range(0, 1 << 21));
            send(x, exp_model(x));
        end
        idle(6);
        stop_frame();
        idle(2);

        // Full frame of zeros
        base = sums_seen;
        for (int i = 0; i < N; i++) send(0, 65536);
        idle(6);
        check("t4_nsum", sums_seen - base, 1);
        check("t4_sum", last_sum, 655360);

        // Back-to-back frames
        base = sums_seen;
        for (int i = 0; i < N; i++) send(-65536, 25515);
        for (int i = 0; i < N; i++) send(0, 65536);
        idle(6);
        check("t5_nsum", sums_seen - base, 2);
        check("t5_sum_a", prev_sum, 255150);
        check("t5_sum_b", last_sum, 655360);

        // Partial frame cut by start_i low
        base = sums_seen;
        for (int i = 0; i < 5; i++) send(0, 65536);
        stop_frame();
        idle(3);
        for (int i = 0; i < N; i++) send(0, 65536);
        idle(6);
        check("t6_stop_nsum", sums_seen - base, 1);
        check("t6_stop_sum", last_sum, 655360);

        // Partial frame cut by reset
        base = sums_seen;
        for (int i = 0; i < 5; i++) send(0, 65536);
        reset_pulse();
        drive(1'b0, 1'b0, '0);
        for (int i = 0; i < N; i++) send(0, 65536);
        idle(6);
        check("t6_rst_nsum", sums_seen - base, 1);
        check("t6_rst_sum", last_sum, 655360);

        // Random frame with gaps
        base = sums_seen;
        for (int i = 0; i < N; i++) begin
            x = -longint'($urandom_range(0, 1 << 20));
            send(x, exp_model(x));
            idle(int'($urandom_range(0, 2)));
        end
        idle(8);
        check("rand_nsum", sums_seen - base, 1);
        check("sum_hold", longint'(sum_o), model_last_sum);

        check("exp_q_empty", exp_q.size(), 0);
        check("sum_q_empty", sum_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
